// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: state encoding, widths,
// default timeout and the conditional magnitude helper.
package mult_sequencer_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned DEF_TIMEOUT = 40;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Two's-complement magnitude when neg_in is set, pass-through otherwise.
  // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] abs32(input logic neg_in,
                                               input logic [WORD_W-1:0] v);
    return neg_in ? (~v + WORD_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_sequencer.sv
// Control wrapper between main control and the shift-add multiplier:
// converts signed operands to magnitudes, sequences the multiplier,
// sign-corrects the 64-bit product and commits it to HI/LO.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              signed_op,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              mult_reset,
  output logic              mult_ctrl,
  output logic [WORD_W-1:0] fator_a,
  output logic [WORD_W-1:0] fator_b,
  input  logic [WORD_W-1:0] mult_hi,
  input  logic [WORD_W-1:0] mult_lo,
  input  logic              mult_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  state_t                state;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;
  logic [2*WORD_W-1:0]   product;
  logic [2*WORD_W-1:0]   prod_fix;

  // Sign-corrected product, applied across the full 64 bits.
  always_comb begin
    prod_fix = product;
    if (neg) prod_fix = ~product + (2*WORD_W)'(1);
  end

  // Sequencer FSM; every output is registered and reflects the state entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      neg         <= 1'b0;
      cnt         <= '0;
      product     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      mult_reset  <= 1'b0;
      mult_ctrl   <= 1'b0;
      fator_a     <= '0;
      fator_b     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            neg         <= signed_op & (op_a[WORD_W-1] ^ op_b[WORD_W-1]);
            fator_a     <= abs32(signed_op & op_a[WORD_W-1], op_a);
            fator_b     <= abs32(signed_op & op_b[WORD_W-1], op_b);
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            mult_reset  <= 1'b1;
            mult_ctrl   <= 1'b0;
            state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt        <= '0;
          mult_reset <= 1'b0;
          if (abort) begin
            mult_ctrl <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            mult_ctrl <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            mult_ctrl <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (mult_out) begin
            product   <= {mult_hi, mult_lo};
            mult_ctrl <= 1'b0;
            state     <= S_FIX;
          end else if (cnt + CNT_W'(1) == CNT_LAST) begin
            timeout_err <= 1'b1;
            mult_ctrl   <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // Correction and commit share this edge so hi/lo and done
            // appear together in the DONE cycle.
            product <= prod_fix;
            hi      <= prod_fix[2*WORD_W-1:WORD_W];
            lo      <= prod_fix[WORD_W-1:0];
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mult_reset <= 1'b0;
          mult_ctrl  <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
